// File: rtl/prio_enc_pkg.sv
// Shared helpers and types for the prio_enc_queue block.
package prio_enc_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_enc_queue_pick.sv
// Combinational downward search from a start pointer, wrapping from 0 to N-1.
module prio_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] pos_s;

  // First set bit at start, start-1, ... with wrap; earlier positions win.
  always_comb begin
    idx   = {IW{1'b0}};
    found = 1'b0;
    pos_s = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (start >= IW'(i)) begin
        pos_s = start - IW'(i);
      end else begin
        pos_s = start + IW'(N - i);
      end
      if (!found && vec[pos_s]) begin
        found = 1'b1;
        idx   = pos_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/prio_enc_queue.sv
// Sticky-pending priority encoder issuing one index at a time on valid/ready.
// Define PRIO_ENC_QUEUE_RR_EN for round-robin search instead of fixed MSB-first.
module prio_enc_queue
  import prio_enc_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = clog2_min1(N),
  parameter int CW = clog2_min1(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          flush_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [N-1:0]  pending_o,
  output logic [CW-1:0] cnt_o,
  output logic          busy_o
);

  logic [N-1:0]  pend_r, pend_nx_s, eff_s;
  logic [IW-1:0] idx_r, idx_nx_s, pick_s, start_s;
  logic          valid_r, valid_nx_s, load_s, found_s;

  assign eff_s  = pend_r | req_i;
  assign load_s = !valid_r || ready_i;

`ifdef PRIO_ENC_QUEUE_RR_EN
  logic [IW-1:0] last_r, last_nx_s;

  assign start_s = (last_r == {IW{1'b0}}) ? IW'(N - 1) : (last_r - IW'(1));

  // Remember the most recent grant so the next search begins just below it.
  always_comb begin
    last_nx_s = last_r;
    if (!flush_i && load_s && found_s) begin
      last_nx_s = pick_s;
    end else begin
      last_nx_s = last_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= IW'(N - 1);
    end else begin
      last_r <= last_nx_s;
    end
  end
`else
  assign start_s = IW'(N - 1);
`endif

  prio_pick #(.N(N), .IW(IW)) u_pick (
    .vec   (eff_s),
    .start (start_s),
    .idx   (pick_s),
    .found (found_s)
  );

  // Next state: valid_r is the EMPTY/HOLD state; flush beats everything.
  always_comb begin
    pend_nx_s  = eff_s;
    valid_nx_s = valid_r;
    idx_nx_s   = idx_r;
    if (flush_i) begin
      pend_nx_s  = {N{1'b0}};
      valid_nx_s = 1'b0;
    end else if (load_s) begin
      if (found_s) begin
        idx_nx_s   = pick_s;
        valid_nx_s = 1'b1;
        pend_nx_s  = eff_s & ~(N'(1'b1) << pick_s);
      end else begin
        valid_nx_s = 1'b0;
      end
    end else begin
      pend_nx_s = eff_s;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r  <= {N{1'b0}};
      valid_r <= 1'b0;
      idx_r   <= {IW{1'b0}};
    end else begin
      pend_r  <= pend_nx_s;
      valid_r <= valid_nx_s;
      idx_r   <= idx_nx_s;
    end
  end

  assign idx_o     = idx_r;
  assign valid_o   = valid_r;
  assign pending_o = pend_r;
  assign cnt_o     = CW'(popcount(64'(pend_r)));
  assign busy_o    = (|pend_r) || valid_r;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Scoreboard bench for prio_enc_queue (N=8); honours PRIO_ENC_QUEUE_RR_EN.
module tb_prio_enc_queue;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic          flush_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [IW-1:0] idx_o;
  logic          valid_o;
  logic [N-1:0]  pending_o;
  logic [CW-1:0] cnt_o;
  logic          busy_o;

  prio_enc_queue #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .flush_i   (flush_i),
    .idx_o     (idx_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .pending_o (pending_o),
    .cnt_o     (cnt_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: set of pending requests, whether a grant is held, last grant.
  logic [N-1:0] pend_m = '0;
  bit           vld_m  = 1'b0;
  int           last_m = N - 1;
  int           exp_q[$];
  int           acc_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_m = '0;
    vld_m  = 1'b0;
    last_m = N - 1;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] r, input bit rd, input bit f);
    logic [N-1:0] eff;
    int k;
    eff = pend_m | r;
    k = -1;
    if (f) begin
      if (vld_m && !rd) void'(exp_q.pop_back());
      pend_m = '0;
      vld_m  = 1'b0;
    end else if (!vld_m || rd) begin
`ifdef PRIO_ENC_QUEUE_RR_EN
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (last_m - i + N) % N;
        if (k < 0 && eff[c]) k = c;
      end
`else
      for (int c = N - 1; c >= 0; c--) begin
        if (k < 0 && eff[c]) k = c;
      end
`endif
      if (k >= 0) begin
        exp_q.push_back(k);
        eff[k] = 1'b0;
        vld_m  = 1'b1;
        last_m = k;
      end else begin
        vld_m = 1'b0;
      end
      pend_m = eff;
    end else begin
      pend_m = eff;
    end
  endtask

  // Drive one cycle's inputs, advance the model at the edge, return at edge+1.
  task automatic step(input logic [N-1:0] r, input bit rd, input bit f);
    req_i   = r;
    ready_i = rd;
    flush_i = f;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(r, rd, f);
    #1;
  endtask

  // Monitor: compare visible state each cycle, pop expected grants on handshake.
  always @(negedge clk) begin
    chk("valid", 64'(valid_o), 64'(vld_m));
    chk("pending", 64'(pending_o), 64'(pend_m));
    chk("cnt", 64'(cnt_o), 64'($countones(pend_m)));
    chk("busy", 64'(busy_o), 64'((pend_m != '0) || vld_m));
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idx: valid with no expected grant, got %0d", idx_o);
      end else begin
        chk("idx", 64'(idx_o), 64'(exp_q[0]));
        if (ready_i) begin
          acc_log.push_back(int'(idx_o));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int ord[9];
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step('0, 1'b1, 1'b0);

    // Two requests in one pulse drain MSB first.
    acc_log.delete();
    step(8'b0010_0100, 1'b1, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);
    chk("t1_grants", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() == 2) begin
      chk("t1_first", 64'(acc_log[0]), 64'd5);
      chk("t1_second", 64'(acc_log[1]), 64'd2);
    end

    // Back-pressure holds idx 7 while bit 0 waits.
    step(8'h81, 1'b0, 1'b0);
    repeat (5) step('0, 1'b0, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);

    // Re-request of the held index is granted again.
    acc_log.delete();
    step(8'h08, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);
    chk("t3_grants", 64'(acc_log.size()), 64'd2);

    // Flush with a same-cycle request drops everything.
    step(8'hF0, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b1);
    chk("t4_valid", 64'(valid_o), 64'd0);
    chk("t4_busy", 64'(busy_o), 64'd0);
    step('0, 1'b1, 1'b0);

    // Asynchronous reset mid-hold clears outputs before the next edge.
    step(8'h40, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_pending", 64'(pending_o), 64'd0);
    chk("rst_cnt", 64'(cnt_o), 64'd0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step('0, 1'b1, 1'b0);

    // Grant index 0 first so the next search starts from the top.
    step(8'h01, 1'b1, 1'b0);
    repeat (2) step('0, 1'b1, 1'b0);
    acc_log.delete();
    repeat (9) step(8'hFF, 1'b1, 1'b0);
    repeat (N + 2) step('0, 1'b1, 1'b0);
`ifdef PRIO_ENC_QUEUE_RR_EN
    ord = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
    ord = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif
    chk("ff_grants", 64'(acc_log.size() >= 9), 64'd1);
    for (int i = 0; i < 9; i++) begin
      if (i < acc_log.size()) chk("ff_order", 64'(acc_log[i]), 64'(ord[i]));
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    repeat (2 * N + 2) step('0, 1'b1, 1'b0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
